// File: rtl/toggle_push_tx.sv
// Transmit side of a toggle-handshake clock-domain crossing: launches one word per
// xfer_req toggle and waits for the returning xfer_ack toggle before the next.
module toggle_push_tx #(
    parameter int DATAWIDTH = 8,
    parameter int OVERWRITE = 0,
    parameter int CNTWIDTH  = 8,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [DATAWIDTH-1:0] i,
    output logic [DATAWIDTH-1:0] xfer,
    output logic                 xfer_req,
    input  logic                 xfer_ack,
    output logic                 busy,
    output logic [CNTWIDTH-1:0]  overwrite_count,
    output logic                 timeout
);
    // state | meaning
    // IDLE  | nothing outstanding; xfer holds the last launched word
    // WAIT  | word on xfer launched, waiting for the far-end ack toggle
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam bit OW = (OVERWRITE != 0);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    state_t                 state, state_n;
    logic                   ack_sync1, ack_sync2, ack_prev, ack_pulse;
    logic [DATAWIDTH-1:0]   pend, pend_n;
    logic                   pend_valid, pend_valid_n;
    logic [DATAWIDTH-1:0]   xfer_n, launch_word;
    logic                   req_n, timeout_n;
    logic [CNTWIDTH-1:0]    cnt_n;
    logic [TW-1:0]          timer, timer_n;
    logic                   accept, launch, drop;

    assign ack_pulse = ack_sync2 ^ ack_prev;
    assign i_ready   = OW || (state == IDLE) || !pend_valid;
    assign accept    = i_valid && i_ready;
    assign busy      = (state == WAIT);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state           <= IDLE;
            ack_sync1       <= 1'b0;
            ack_sync2       <= 1'b0;
            ack_prev        <= 1'b0;
            pend            <= '0;
            pend_valid      <= 1'b0;
            xfer            <= '0;
            xfer_req        <= 1'b0;
            overwrite_count <= '0;
            timer           <= '0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_n;
            ack_sync1       <= xfer_ack;
            ack_sync2       <= ack_sync1;
            ack_prev        <= ack_sync2;
            pend            <= pend_n;
            pend_valid      <= pend_valid_n;
            xfer            <= xfer_n;
            xfer_req        <= req_n;
            overwrite_count <= cnt_n;
            timer           <= timer_n;
            timeout         <= timeout_n;
        end
    end

    always_comb begin
        state_n      = state;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        xfer_n       = xfer;
        req_n        = xfer_req;
        cnt_n        = overwrite_count;
        timer_n      = timer;
        timeout_n    = timeout;
        launch       = 1'b0;
        launch_word  = i;
        drop         = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (accept) begin
                    launch  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (ack_pulse) begin
                    // A fresh word beats a pending one only in latest-value-wins mode.
                    if (accept && OW) begin
                        launch       = 1'b1;
                        drop         = pend_valid;
                        pend_valid_n = 1'b0;
                    end else if (pend_valid) begin
                        launch       = 1'b1;
                        launch_word  = pend;
                        pend_valid_n = 1'b0;
                    end else if (accept) begin
                        launch = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (accept) begin
                    pend_n       = i;
                    pend_valid_n = 1'b1;
                    drop         = pend_valid;
                end

                if (launch) begin
                    timer_n = '0;
                end else if (timer != TMAX) begin
                    timer_n = timer + 1'b1;
                    if (timer_n == TMAX) timeout_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (launch) begin
            xfer_n = launch_word;
            req_n  = ~xfer_req;
        end
        if (drop && (overwrite_count != {CNTWIDTH{1'b1}})) cnt_n = overwrite_count + 1'b1;
    end
endmodule
